// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable baud, 5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits. Uses 3-sample majority voting around mid-bit and
// reports parity error, framing error and line break.
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 125000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] out,
  output logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int DIV   = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW    = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] T_VOTE = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

  state_t               state, state_n;
  logic                 rx_m, rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [TW-1:0]        t;
  logic [3:0]           bit_cnt;
  logic                 s0, s1;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_r, frm_err_r, par_bit_r;
  logic                 vote, at_vote, at_end, last_data, last_stop;
  logic                 frm_err_now, is_break;

  // Two-flop synchroniser; resets to idle-high so release never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  // Free-running oversample tick divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             div_cnt <= '0;
    else if (div_cnt == DIV_W'(DIV - 1)) div_cnt <= '0;
    else                                 div_cnt <= div_cnt + 1'b1;
  end

  // Per-bit decode terms; the third sample is the live rx_s at the vote tick
  always_comb begin
    tick        = (div_cnt == DIV_W'(DIV - 1));
    vote        = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    at_vote     = tick && (t == T_VOTE);
    at_end      = tick && (t == T_END);
    last_data   = (bit_cnt == 4'(DATA_BITS - 1));
    last_stop   = (bit_cnt == 4'(STOP_BITS - 1));
    frm_err_now = frm_err_r | ~vote;
    is_break    = frm_err_now && (shreg == '0) && ((PARITY == 0) || !par_bit_r);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (tick && !rx_s) state_n = START;
      START: if (at_vote && vote) state_n = IDLE;
             else if (at_end)     state_n = DATA;
      DATA:  if (at_end && last_data) state_n = (PARITY != 0) ? PAR : STOP;
      PAR:   if (at_end) state_n = STOP;
      STOP:  if (at_vote && last_stop) state_n = is_break ? BRK : IDLE;
      BRK:   if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bit timing, sampling, shifting, error records and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t          <= '0;
      bit_cnt    <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      shreg      <= '0;
      par_err_r  <= 1'b0;
      frm_err_r  <= 1'b0;
      par_bit_r  <= 1'b0;
      out        <= '0;
      ready      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      ready     <= 1'b0;
      break_det <= 1'b0;
      if (tick) begin
        // The detecting tick in IDLE counts as t=0 of the start bit
        if (state == IDLE)   t <= TW'(1);
        else if (t == T_END) t <= '0;
        else                 t <= t + 1'b1;
        if (t == T_S0) s0 <= rx_s;
        if (t == T_S1) s1 <= rx_s;
      end
      if (at_end) begin
        if ((state == DATA && !last_data) || state == STOP) bit_cnt <= bit_cnt + 4'd1;
        else                                                bit_cnt <= '0;
      end
      if (at_vote) begin
        case (state)
          START: begin
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
            par_bit_r <= 1'b0;
          end
          DATA: shreg <= {vote, shreg[DATA_BITS-1:1]};
          PAR: begin
            par_bit_r <= vote;
            par_err_r <= ((^shreg) ^ vote) != (PARITY == 1);
          end
          STOP: begin
            frm_err_r <= frm_err_now;
            // Deliver on the last stop bit's vote so a back-to-back start edge is not missed
            if (last_stop) begin
              out        <= shreg;
              ready      <= 1'b1;
              parity_err <= par_err_r;
              frame_err  <= frm_err_now;
              break_det  <= is_break;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg. Line rate is raised (640 ns bit, 16 ticks of
// 5 clocks) to keep the run short; glitch/pulse widths scale with the bit time.
// Instance a: 8N1. Instance b: 7 data bits, even parity, 2 stop bits.
module tb_uart_rx_cfg;
  localparam int BIT = 640;

  logic       clk = 1'b0, rst = 1'b1, rx_a = 1'b1, rx_b = 1'b1;
  logic [7:0] out_a;
  logic [6:0] out_b;
  logic       ready_a, pe_a, fe_a, bd_a;
  logic       ready_b, pe_b, fe_b, bd_b;

  uart_rx_cfg #(.CLK_FREQ(125000000), .BAUD(1562500)) dut_a (
    .clk(clk), .rst(rst), .rx_in(rx_a), .out(out_a), .ready(ready_a),
    .parity_err(pe_a), .frame_err(fe_a), .break_det(bd_a));

  uart_rx_cfg #(.CLK_FREQ(125000000), .BAUD(1562500), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .rx_in(rx_b), .out(out_b), .ready(ready_b),
    .parity_err(pe_b), .frame_err(fe_b), .break_det(bd_b));

  always #4 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ready monitors: count pulses, capture the delivered frame, catch stretched pulses
  int         na = 0, nb = 0, brk_a = 0, brk_b = 0, multi = 0;
  logic [7:0] q_a[$];
  logic [7:0] o_a;
  logic [6:0] o_b;
  logic       pe_la, fe_la, bd_la, pe_lb, fe_lb, bd_lb, prev_a = 0, prev_b = 0;
  time        t_rdy_a;

  always @(negedge clk) begin
    if (ready_a) begin
      na++; o_a = out_a; pe_la = pe_a; fe_la = fe_a; bd_la = bd_a;
      q_a.push_back(out_a); t_rdy_a = $time;
    end
    if (ready_b) begin
      nb++; o_b = out_b; pe_lb = pe_b; fe_lb = fe_b; bd_lb = bd_b;
    end
    if (bd_a) brk_a++;
    if (bd_b) brk_b++;
    if ((ready_a && prev_a) || (ready_b && prev_b)) multi++;
    prev_a = ready_a;
    prev_b = ready_b;
  end

  // Drive n line bits LSB-first onto line a (sel=0) or b (sel=1)
  task automatic send(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx_a = bits[i];
      else          rx_b = bits[i];
      #(BIT);
    end
  endtask

  task automatic frame_a(input logic [7:0] d, input logic stop);
    send(0, {6'h3f, stop, d, 1'b0}, 10);
  endtask

  task automatic frame_b(input logic [6:0] d, input logic par, input logic st1, input logic st2);
    send(1, {5'h1f, st2, st1, par, d, 1'b0}, 11);
  endtask

  time ts;
  int  lat, n_save;

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_out", {24'd0, out_a}, 32'h0);
    chk("rst_flags", {ready_a, pe_a, fe_a, bd_a}, 4'h0);
    rst = 1'b0;
    #(2*BIT);
    chk("no_false_start", na, 0);

    // 1: plain frame and its latency
    ts = $time;
    frame_a(8'h49, 1'b1);
    #(BIT);
    lat = int'(t_rdy_a - ts);
    chk("t1_count", na, 1);
    chk("t1_out", o_a, 8'h49);
    chk("t1_errs", {pe_la, fe_la, bd_la}, 3'b000);
    chk("t1_latency", (lat >= 6000 && lat <= 6240), 1);

    // 2: back-to-back frames, no idle gap
    frame_a(8'h00, 1'b1);
    frame_a(8'hFF, 1'b1);
    #(BIT);
    chk("t2_count", na, 3);
    chk("t2_first", q_a[1], 8'h00);
    chk("t2_second", q_a[2], 8'hFF);
    chk("t2_errs", {pe_la, fe_la, bd_la}, 3'b000);

    // 3: framing error, then a break, then recovery
    frame_a(8'h3C, 1'b0);
    rx_a = 1'b1;
    #(2*BIT);
    chk("t3_fe_count", na, 4);
    chk("t3_fe_out", o_a, 8'h3C);
    chk("t3_fe_flags", {fe_la, bd_la}, 2'b10);
    rx_a = 1'b0;
    #(30*BIT);
    chk("t3_brk_count", na, 5);
    chk("t3_brk_pulses", brk_a, 1);
    chk("t3_brk_out", o_a, 8'h00);
    chk("t3_brk_flags", {fe_la, bd_la}, 2'b11);
    rx_a = 1'b1;
    #(2*BIT);
    frame_a(8'h55, 1'b1);
    #(BIT);
    chk("t3_after_count", na, 6);
    chk("t3_after_out", o_a, 8'h55);
    chk("t3_after_errs", {pe_la, fe_la, bd_la}, 3'b000);

    // 4: start glitch rejected; short mid-bit pulse outvoted
    rx_a = 1'b0;
    #160;
    rx_a = 1'b1;
    #(2*BIT);
    chk("t4_glitch", na, 6);
    frame_a(8'hA5, 1'b1);
    #(BIT);
    chk("t4_a5_count", na, 7);
    chk("t4_a5_out", o_a, 8'hA5);
    fork
      frame_a(8'hA5, 1'b1);
      begin
        #(4*BIT + BIT/2 - 11);
        rx_a = ~rx_a;
        #22;
        rx_a = ~rx_a;
      end
    join
    #(BIT);
    chk("t4_pulse_count", na, 8);
    chk("t4_pulse_out", o_a, 8'hA5);

    // 5: 7E2 instance: 0x5A has four ones, even parity bit is 0
    frame_b(7'h5A, 1'b0, 1'b1, 1'b1);
    #(BIT);
    chk("t5_count1", nb, 1);
    chk("t5_out1", o_b, 7'h5A);
    chk("t5_errs1", {pe_lb, fe_lb, bd_lb}, 3'b000);
    frame_b(7'h5A, 1'b1, 1'b1, 1'b1);
    #(BIT);
    chk("t5_count2", nb, 2);
    chk("t5_errs2", {pe_lb, fe_lb, bd_lb}, 3'b100);
    frame_b(7'h5A, 1'b0, 1'b1, 1'b0);
    rx_b = 1'b1;
    #(2*BIT);
    chk("t5_count3", nb, 3);
    chk("t5_errs3", {pe_lb, fe_lb, bd_lb}, 3'b010);
    chk("t5_no_brk", brk_b, 0);

    // 6: reset mid data bit 4 kills the partial frame
    send(0, {8'hff, 8'hC3, 1'b0}, 5);
    rx_a = 1'b0;
    #(BIT/2 + 3);
    n_save = na;
    rst = 1'b1;
    #1;
    chk("t6_rst_out", {24'd0, out_a}, 32'h0);
    chk("t6_rst_flags", {ready_a, pe_a, fe_a, bd_a}, 4'h0);
    #20;
    rst = 1'b0;
    rx_a = 1'b1;
    #(3*BIT);
    chk("t6_no_partial", na, n_save);
    frame_a(8'hC3, 1'b1);
    #(BIT);
    chk("t6_count", na, n_save + 1);
    chk("t6_out", o_a, 8'hC3);

    chk("ready_single_cycle", multi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
